// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Holds operation codes, FSM states and the iteration count.
// No logic; imported by mdu_iter and mdu_divstep.
package mdu_pkg;

  localparam int ITER  = 32;
  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10
  } state_e;

endpackage

// File: rtl/mdu_divstep.sv
// One restoring-division step: shift in a dividend bit, trial-subtract divisor.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module mdu_divstep
  import mdu_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [DW-1:0] i_rem,
  input  logic [DW-1:0] i_div,
  input  logic          i_bit,
  output logic [DW-1:0] o_rem,
  output logic          o_qbit
);

  logic [DW:0] w_shift;
  logic [DW:0] w_diff;

  // Trial subtraction. The partial remainder is always below the divisor (or,
  // for a zero divisor, below 2^31 before the last step), so bit DW of the
  // difference is exactly the borrow.
  always_comb begin
    w_shift = {i_rem, i_bit};
    w_diff  = w_shift - {1'b0, i_div};
    o_qbit  = ~w_diff[DW];
    o_rem   = o_qbit ? w_diff[DW-1:0] : w_shift[DW-1:0];
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU into private HI/LO registers.
// Latency: Busy for 33 cycles after the Start edge, Done pulses the cycle after.
// Backpressure: Start and HI/LO writes are ignored while Busy; controller stalls on Busy.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          Clk,
  input  logic          Clrn,
  input  logic          Start,
  input  logic [1:0]    Op,
  input  logic [DW-1:0] A,
  input  logic [DW-1:0] B,
  input  logic          HiWe,
  input  logic          LoWe,
  input  logic [DW-1:0] Wdata,
  output logic          Busy,
  output logic          Done,
  output logic [DW-1:0] Hi,
  output logic [DW-1:0] Lo
);

  state_e            r_state, w_next;
  logic [CNT_W-1:0]  r_cnt;
  op_e               r_op;
  logic              r_negq, r_negr, r_dz;
  logic [DW-1:0]     r_opb;      // multiplicand (mult) or divisor (div), magnitude
  logic [2*DW-1:0]   r_p;        // {acc, multiplier} or {remainder, dividend/quotient}
  logic              r_busy, r_done;
  logic [DW-1:0]     r_hi, r_lo;

  logic              w_signed, w_sa, w_sb, w_is_div;
  logic [DW-1:0]     w_absa, w_absb;
  logic [DW:0]       w_sum;
  logic [2*DW-1:0]   w_pm, w_pd, w_prod;
  logic [DW-1:0]     w_rem;
  logic              w_qbit;
  logic [DW-1:0]     w_q, w_r;

  mdu_divstep #(.DW(DW)) u_divstep (
    .i_rem  (r_p[2*DW-1:DW]),
    .i_div  (r_opb),
    .i_bit  (r_p[DW-1]),
    .o_rem  (w_rem),
    .o_qbit (w_qbit)
  );

  // Operand magnitudes, one step of each datapath, and the final sign fix.
  always_comb begin
    w_signed = (Op == OP_MULT) || (Op == OP_DIV);
    w_sa     = w_signed & A[DW-1];
    w_sb     = w_signed & B[DW-1];
    w_absa   = w_sa ? (~A + 1'b1) : A;
    w_absb   = w_sb ? (~B + 1'b1) : B;
    w_is_div = (r_op == OP_DIV) || (r_op == OP_DIVU);
    w_sum    = {1'b0, r_p[2*DW-1:DW]} + (r_p[0] ? {1'b0, r_opb} : {(DW+1){1'b0}});
    w_pm     = {w_sum, r_p[DW-1:1]};
    w_pd     = {w_rem, r_p[DW-2:0], w_qbit};
    w_prod   = r_negq ? (~r_p + 1'b1) : r_p;
    // A zero divisor leaves the dividend magnitude as remainder, so Hi=A falls out
    // of the normal remainder sign fix; only the quotient needs forcing.
    w_q      = r_dz ? {DW{1'b1}} : (r_negq ? (~r_p[DW-1:0] + 1'b1) : r_p[DW-1:0]);
    w_r      = r_negr ? (~r_p[2*DW-1:DW] + 1'b1) : r_p[2*DW-1:DW];
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (Start) w_next = S_CALC;
      S_CALC:  if (r_cnt == CNT_LAST) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Operand latch, iteration datapath, HI/LO writes and registered status.
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      r_cnt  <= '0;
      r_op   <= OP_MULT;
      r_negq <= 1'b0;
      r_negr <= 1'b0;
      r_dz   <= 1'b0;
      r_opb  <= '0;
      r_p    <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_hi   <= '0;
      r_lo   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (HiWe) r_hi <= Wdata;
          if (LoWe) r_lo <= Wdata;
          if (Start) begin
            r_op   <= op_e'(Op);
            r_negq <= w_sa ^ w_sb;
            r_negr <= w_sa;
            r_dz   <= (B == '0);
            r_cnt  <= '0;
            r_busy <= 1'b1;
            if (Op[1]) begin
              r_p   <= {{DW{1'b0}}, w_absa};
              r_opb <= w_absb;
            end else begin
              r_p   <= {{DW{1'b0}}, w_absb};
              r_opb <= w_absa;
            end
          end
        end
        S_CALC: begin
          r_p   <= w_is_div ? w_pd : w_pm;
          r_cnt <= r_cnt + 1'b1;
        end
        S_FIX: begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          if (w_is_div) begin
            r_hi <= w_r;
            r_lo <= w_q;
          end else begin
            r_hi <= w_prod[2*DW-1:DW];
            r_lo <= w_prod[DW-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign Busy = r_busy;
  assign Done = r_done;
  assign Hi   = r_hi;
  assign Lo   = r_lo;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed self-checking bench for mdu_iter.
// Inputs driven 1 time unit after the rising edge; outputs sampled there too.
// Each run is bounded by a cycle budget; an overall time limit guards the whole bench.
module tb_mdu_iter;

  logic        Clk = 1'b0;
  logic        Clrn = 1'b0;
  logic        Start = 1'b0;
  logic [1:0]  Op = 2'b00;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        HiWe = 1'b0;
  logic        LoWe = 1'b0;
  logic [31:0] Wdata = '0;
  logic        Busy, Done;
  logic [31:0] Hi, Lo;

  int total = 0;
  int bad   = 0;

  mdu_iter #(.DW(32)) dut (
    .Clk(Clk), .Clrn(Clrn), .Start(Start), .Op(Op), .A(A), .B(B),
    .HiWe(HiWe), .LoWe(LoWe), .Wdata(Wdata),
    .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Launch one operation and follow it to completion. If poke>0, a second Start
  // plus an MTHI of 5 is presented on the edge after the poke-th busy cycle.
  task automatic run(input string tag, input logic [1:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] ehi,
                     input logic [31:0] elo, input int poke);
    int n;
    Op = op; A = a; B = b; Start = 1'b1;
    tick();
    Start = 1'b0;
    Op = ~op; A = $urandom; B = $urandom;   // only latched copies may matter
    n = 0;
    while (Busy === 1'b1 && n < 40) begin
      n++;
      chk({tag, ".done_while_busy"}, {31'd0, Done}, 32'd0);
      if (n == poke) begin
        Start = 1'b1; HiWe = 1'b1; Wdata = 32'd5; Op = 2'b11; A = 32'd1; B = 32'd1;
      end
      tick();
      Start = 1'b0; HiWe = 1'b0;
    end
    chk({tag, ".busy_cycles"}, n, 32'd33);
    chk({tag, ".done"}, {31'd0, Done}, 32'd1);
    chk({tag, ".hi"}, Hi, ehi);
    chk({tag, ".lo"}, Lo, elo);
    tick();
    chk({tag, ".done_drop"}, {31'd0, Done}, 32'd0);
  endtask

  initial begin
    // Reset state.
    #3;
    chk("rst.busy", {31'd0, Busy}, 32'd0);
    chk("rst.done", {31'd0, Done}, 32'd0);
    chk("rst.hi", Hi, 32'd0);
    chk("rst.lo", Lo, 32'd0);
    tick();
    Clrn = 1'b1;
    tick();

    run("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0);
    run("mult_neg",  2'b00, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 0);
    run("div_neg",   2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 0);
    run("div_ovf",   2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0);
    run("divu_zero", 2'b11, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, 0);
    run("div_zero_neg", 2'b10, 32'hFFFFFFF9, 32'd0,     32'hFFFFFFF9, 32'hFFFFFFFF, 0);
    run("multu_poke", 2'b01, 32'd6,       32'd7,        32'd0,        32'd42,       10);

    // MTHI in IDLE: Hi takes Wdata, Lo untouched, no Done.
    HiWe = 1'b1; Wdata = 32'd5;
    tick();
    HiWe = 1'b0;
    chk("mthi.hi", Hi, 32'd5);
    chk("mthi.lo", Lo, 32'd42);
    chk("mthi.done", {31'd0, Done}, 32'd0);
    chk("mthi.busy", {31'd0, Busy}, 32'd0);

    // MTLO in IDLE.
    LoWe = 1'b1; Wdata = 32'h12345678;
    tick();
    LoWe = 1'b0;
    chk("mtlo.lo", Lo, 32'h12345678);
    chk("mtlo.hi", Hi, 32'd5);

    // Asynchronous reset in the middle of DIVU 9/2.
    Op = 2'b11; A = 32'd9; B = 32'd2; Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int i = 0; i < 19; i++) tick();
    chk("mid.busy_before", {31'd0, Busy}, 32'd1);
    #2 Clrn = 1'b0;
    #1;
    chk("arst.busy", {31'd0, Busy}, 32'd0);
    chk("arst.done", {31'd0, Done}, 32'd0);
    chk("arst.hi", Hi, 32'd0);
    chk("arst.lo", Lo, 32'd0);
    tick();
    tick();
    Clrn = 1'b1;
    tick();
    chk("post_rst.busy", {31'd0, Busy}, 32'd0);
    run("divu_after_rst", 2'b11, 32'd9, 32'd2, 32'd1, 32'd4, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative multiply/divide unit in the EX stage, directly downstream of the 32x32 register file.
- Consumes the two read-port operands, Qa → A and Qb → B.
- Implements MULT, MULTU, DIV and DIVU over multiple cycles into private HI/LO registers.
- The pipeline controller stalls on Busy and reads Hi/Lo for MFHI/MFLO. Those results then return to the register file write port.

Parameters:
- DW, 32, operand width. Only 32 is supported; the iteration count equals DW.

Ports:
- Clk    in   1   clock; all state changes on its rising edge
- Clrn   in   1   asynchronous active-low reset
- Start  in   1   launch operation; sampled only in IDLE
- Op     in   2   operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- A      in   DW  operand A (register file Qa): multiplicand or dividend
- B      in   DW  operand B (register file Qb): multiplier or divisor
- HiWe   in   1   MTHI write strobe
- LoWe   in   1   MTLO write strobe
- Wdata  in   DW  MTHI/MTLO data
- Busy   out  1   operation in progress; controller stalls while high
- Done   out  1   one-cycle pulse when Hi/Lo take a new result
- Hi     out  DW  HI register (product high word, or remainder)
- Lo     out  DW  LO register (product low word, or quotient)

Behaviour:
- Clock and reset: one clock, Clk. Reset Clrn is asynchronous and active-low.
- While Clrn=0: state=IDLE; Busy=0, Done=0, Hi=0, Lo=0; counter and working registers are 0.
- Reset mid-operation aborts the operation with no partial result. After reset release, the first Start is accepted normally.

State machine:
- States are IDLE, CALC and FIX. All outputs are registered.
- IDLE:
  - On an edge E0 with Start=1, latch Op, |A|, |B| and the sign flags (sign flags only for signed ops).
  - Clear the iteration counter, set Busy=1, go to CALC.
- CALC: one iteration per edge (E1..E32), counter 0..31; go to FIX after counter=31.
  - Multiply: shift-add on a 64-bit {acc, multiplier} register.
  - Divide: restoring division, one quotient bit per edge.
- FIX, at edge E33:
  - Apply sign correction and write Hi/Lo.
  - Busy goes 0, Done goes 1, return to IDLE.
- Done drops at E34.
- Latency: Busy is high for the 33 cycles after E0. Done is visible in exactly one cycle, following E33.
- Start while Busy=1 is ignored. Start during the Done cycle is accepted, because state is IDLE.

Arithmetic:
- MULTU: {Hi,Lo} = A*B, unsigned, 64-bit.
- MULT: two's-complement 64-bit product. Magnitude is computed unsigned, then negated if sign(A) xor sign(B).
- DIVU: Lo = A/B, Hi = A%B.
- DIV: quotient truncates toward zero; remainder takes the sign of the dividend.
- Divide by zero (B=0, DIV or DIVU): Lo=32'hFFFFFFFF, Hi=A. No exception. Still takes the full 33-cycle latency.
- DIV of 32'h80000000 by 32'hFFFFFFFF: Lo=32'h80000000, Hi=0.

HiWe/LoWe:
- In IDLE, Hi or Lo takes Wdata on the edge. No Done pulse.
- Ignored while Busy=1.
- If Start and HiWe/LoWe are asserted in the same IDLE edge, the write takes effect and the operation starts; the write is overwritten at FIX.

Operands:
- A, B and Op may change freely after E0; only the latched copies are used.

Decomposition:
- Package mdu_pkg holds:
  - Op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU.
  - State encoding: S_IDLE, S_CALC, S_FIX.
  - ITER = 32.
- One sub-module, mdu_divstep: a combinational single restoring-division step.
  - Inputs: partial remainder, divisor, next dividend bit.
  - Outputs: new remainder, quotient bit.
- Control, counter, multiply datapath and sign fix live in mdu_iter.

Test Plan:
- MULTU with A=B=32'hFFFFFFFF, Start one cycle:
  - Busy high for 33 cycles; Done pulses once in the 34th cycle after the Start edge.
  - Hi=32'hFFFFFFFE, Lo=32'h00000001.
- MULT with A=-3 (32'hFFFFFFFD), B=7: Hi=32'hFFFFFFFF, Lo=32'hFFFFFFEB.
- DIV with A=-7, B=2: Lo=32'hFFFFFFFD, Hi=32'hFFFFFFFF.
- DIV with A=32'h80000000, B=32'hFFFFFFFF: Lo=32'h80000000, Hi=0.
- DIVU with A=100, B=0: Lo=32'hFFFFFFFF, Hi=100, Done at the normal latency.
- Second Start plus HiWe (Wdata=5) at cycle 10 of a running MULTU 6*7:
  - Both ignored; result Hi=0, Lo=42.
  - Then HiWe with Wdata=5 in IDLE gives Hi=5 and no Done pulse.
- Clrn=0 at cycle 20 of DIVU 9/2:
  - Busy, Done, Hi and Lo go to 0 immediately, without waiting for an edge.
  - After release, Start DIVU 9/2 gives Lo=4, Hi=1.
